// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point configuration for the LSM pricing datapath.
package fpga_cfg_pkg;
    localparam int FP_WIDTH = 32;
    localparam int FP_QINT  = 16;
    localparam int FP_QFRAC = 16;
endpackage

// File: rtl/lsm_exercise_eval_if.sv
// Coefficient, path-sample and result channels of the exercise evaluator.
interface lsm_exercise_eval_if #(
    parameter int WIDTH   = fpga_cfg_pkg::FP_WIDTH,
    parameter int N_PATHS = 10000
);
    localparam int CNT_W = $clog2(N_PATHS) + 1;

    logic                    beta_valid;
    logic [2:0][WIDTH-1:0]   beta;
    logic                    beta_ready;
    logic                    valid_in;
    logic                    ready_in;
    logic signed [WIDTH-1:0] s_in;
    logic signed [WIDTH-1:0] payoff_in;
    logic signed [WIDTH-1:0] cf_in;
    logic                    valid_out;
    logic                    ready_out;
    logic signed [WIDTH-1:0] cont_out;
    logic                    exercise_out;
    logic signed [WIDTH-1:0] cf_out;
    logic                    date_done;
    logic [CNT_W-1:0]        ex_count;

    modport master (
        output beta_valid, beta, valid_in, s_in, payoff_in, cf_in, ready_out,
        input  beta_ready, ready_in, valid_out, cont_out, exercise_out, cf_out,
               date_done, ex_count
    );

    modport slave (
        input  beta_valid, beta, valid_in, s_in, payoff_in, cf_in, ready_out,
        output beta_ready, ready_in, valid_out, cont_out, exercise_out, cf_out,
               date_done, ex_count
    );
endinterface

// File: rtl/lsm_exercise_eval.sv
// Evaluates C = b0 + b1*S + b2*S^2 per path and decides exercise vs hold.
// Latency: 4 cycles accept-to-valid_out, 1 sample/cycle when unstalled.
// Backpressure: valid_out && !ready_out freezes every stage and drops ready_in.
module lsm_exercise_eval #(
    parameter int WIDTH   = fpga_cfg_pkg::FP_WIDTH,
    parameter int QINT    = fpga_cfg_pkg::FP_QINT,
    parameter int QFRAC   = fpga_cfg_pkg::FP_QFRAC,
    parameter int N_PATHS = 10000
) (
    input logic              clk,
    input logic              rst_n,
    lsm_exercise_eval_if.slave bus
);
    localparam int CNT_W = $clog2(N_PATHS) + 1;
    localparam int PW    = 2 * WIDTH;
    localparam int SW    = WIDTH + 1;

    typedef logic signed [WIDTH-1:0] word_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam word_t W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam word_t W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    if (QINT + QFRAC != WIDTH) begin : g_bad_q
        $error("lsm_exercise_eval: QINT + QFRAC must equal WIDTH");
    end

    // Floor shift of the full product, then clamp if the upper bits are not pure sign.
    function automatic word_t sat_mul(input word_t a, input word_t b);
        logic signed [PW-1:0] p;
        p = PW'(a) * PW'(b);
        p = p >>> QFRAC;
        if (p[PW-1:WIDTH-1] == {(WIDTH+1){p[PW-1]}})
            sat_mul = p[WIDTH-1:0];
        else
            sat_mul = p[PW-1] ? W_MIN : W_MAX;
    endfunction

    function automatic word_t sat_add(input word_t a, input word_t b);
        logic signed [SW-1:0] s;
        s = SW'(a) + SW'(b);
        if (s[WIDTH] == s[WIDTH-1])
            sat_add = s[WIDTH-1:0];
        else
            sat_add = s[WIDTH] ? W_MIN : W_MAX;
    endfunction

    state_t           state;
    word_t            b0, b1, b2;
    logic [CNT_W-1:0] in_cnt, out_cnt, ex_cnt;
    logic             ex_restart;
    logic             beta_ready_q, date_done_q;

    logic  v1, v2, v3, valid_q;
    word_t s1_m, s1_s, s1_p, s1_c;
    word_t s2_a, s2_s, s2_p, s2_c;
    word_t s3_m, s3_p, s3_c;
    word_t cont_q, cf_q;
    logic  ex_q;

    logic  stall, adv, ready_in_c, accept, out_fire, ex_nxt;
    word_t c_nxt;

    assign stall      = valid_q && !bus.ready_out;
    assign adv        = !stall;
    assign ready_in_c = (state == RUN) && !stall;
    assign accept     = bus.valid_in && ready_in_c;
    assign out_fire   = valid_q && bus.ready_out;
    assign c_nxt      = sat_add(b0, s3_m);
    assign ex_nxt     = (s3_p > 0) && (s3_p >= c_nxt);

    assign bus.beta_ready   = beta_ready_q;
    assign bus.ready_in     = ready_in_c;
    assign bus.valid_out    = valid_q;
    assign bus.cont_out     = cont_q;
    assign bus.exercise_out = ex_q;
    assign bus.cf_out       = cf_q;
    assign bus.date_done    = date_done_q;
    assign bus.ex_count     = ex_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; valid_q <= 1'b0;
            s1_m <= '0; s1_s <= '0; s1_p <= '0; s1_c <= '0;
            s2_a <= '0; s2_s <= '0; s2_p <= '0; s2_c <= '0;
            s3_m <= '0; s3_p <= '0; s3_c <= '0;
            cont_q <= '0; cf_q <= '0; ex_q <= 1'b0;
        end else if (adv) begin
            v1      <= accept;
            v2      <= v1;
            v3      <= v2;
            valid_q <= v3;
            if (accept) begin
                s1_m <= sat_mul(b2, bus.s_in);
                s1_s <= bus.s_in;
                s1_p <= bus.payoff_in;
                s1_c <= bus.cf_in;
            end
            if (v1) begin
                s2_a <= sat_add(b1, s1_m);
                s2_s <= s1_s;
                s2_p <= s1_p;
                s2_c <= s1_c;
            end
            if (v2) begin
                s3_m <= sat_mul(s2_a, s2_s);
                s3_p <= s2_p;
                s3_c <= s2_c;
            end
            if (v3) begin
                cont_q <= c_nxt;
                ex_q   <= ex_nxt;
                cf_q   <= ex_nxt ? s3_p : s3_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            beta_ready_q <= 1'b0;
            date_done_q  <= 1'b0;
            b0 <= '0; b1 <= '0; b2 <= '0;
            in_cnt <= '0; out_cnt <= '0; ex_cnt <= '0;
            ex_restart   <= 1'b0;
        end else begin
            date_done_q <= 1'b0;
            if (out_fire) begin
                out_cnt <= out_cnt + 1'b1;
                // ex_count keeps last date's total until this date's first result.
                if (ex_restart) begin
                    ex_cnt     <= CNT_W'(ex_q);
                    ex_restart <= 1'b0;
                end else begin
                    ex_cnt <= ex_cnt + CNT_W'(ex_q);
                end
            end
            case (state)
                IDLE: begin
                    if (bus.beta_valid && beta_ready_q) begin
                        b0           <= bus.beta[0];
                        b1           <= bus.beta[1];
                        b2           <= bus.beta[2];
                        beta_ready_q <= 1'b0;
                        state        <= RUN;
                    end else begin
                        beta_ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        in_cnt <= in_cnt + 1'b1;
                        if (in_cnt == CNT_W'(N_PATHS - 1))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_cnt == CNT_W'(N_PATHS)) begin
                        date_done_q  <= 1'b1;
                        in_cnt       <= '0;
                        out_cnt      <= '0;
                        ex_restart   <= 1'b1;
                        beta_ready_q <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsm_exercise_eval.sv
// Directed-vector bench for lsm_exercise_eval with 8 paths per date, Q16.16.
module tb_lsm_exercise_eval;
    localparam int W = 32;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsm_exercise_eval_if #(.WIDTH(W), .N_PATHS(N)) bus();

    lsm_exercise_eval #(.WIDTH(W), .QINT(16), .QFRAC(16), .N_PATHS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] v_s [N];
    logic [31:0] v_p [N];
    logic [31:0] v_cf[N];
    logic [31:0] e_c [N];
    logic [31:0] e_cf[N];
    logic        e_ex[N];
    int          e_cnt;

    function automatic logic [31:0] q(input int x);
        return 32'(x * 65536);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [31:0] s, input logic [31:0] p,
                           input logic [31:0] cf, input logic [31:0] c, input logic ex,
                           input logic [31:0] ecf);
        v_s[i] = s; v_p[i] = p; v_cf[i] = cf;
        e_c[i] = c; e_ex[i] = ex; e_cf[i] = ecf;
    endtask

    task automatic load_beta(input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2);
        bit ok = 1'b0;
        @(negedge clk);
        bus.beta       = {b2, b1, b0};
        bus.beta_valid = 1'b1;
        for (int k = 0; k < 10 && !ok; k++) begin
            #1;
            if (bus.beta_ready) ok = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        bus.beta_valid = 1'b0;
        chk("beta_load", 32'(ok), 32'd1);
    endtask

    // One exercise date: stream v_* in, check every presented result against e_*.
    task automatic run_date(input string nm, input bit bp, input bit junk,
                            input int max_acc, input bit chk_lat);
        int  i = 0, j = 0, cyc = 0, acc_cyc = -1;
        bit  done = 1'b0, seen_valid = 1'b0, drain_seen = 1'b0, acc, ofire;
        while (!done && cyc < 300) begin
            @(negedge clk);
            bus.ready_out  = bp ? ((cyc % 3) == 0) : 1'b1;
            bus.valid_in   = 1'b1;
            bus.s_in       = (i < N) ? v_s[i]  : q(100);
            bus.payoff_in  = (i < N) ? v_p[i]  : q(100);
            bus.cf_in      = (i < N) ? v_cf[i] : q(100);
            bus.beta_valid = junk && (i < N);
            bus.beta       = {q(50), q(50), q(50)};
            #1;
            if (junk && i == 2) chk({nm, "_beta_rdy_run"}, 32'(bus.beta_ready), 32'd0);
            if (i == N && !drain_seen) begin
                chk({nm, "_drain_rdy_in"}, 32'(bus.ready_in), 32'd0);
                drain_seen = 1'b1;
            end
            acc = bus.valid_in && bus.ready_in;
            if (bus.valid_out) begin
                if (j < N) begin
                    chk($sformatf("%s_c%0d", nm, j),   bus.cont_out,           e_c[j]);
                    chk($sformatf("%s_ex%0d", nm, j),  32'(bus.exercise_out),  32'(e_ex[j]));
                    chk($sformatf("%s_cf%0d", nm, j),  bus.cf_out,             e_cf[j]);
                end else begin
                    chk({nm, "_extra_out"}, 32'(j), 32'(N - 1));
                end
                if (chk_lat && !seen_valid) chk({nm, "_latency"}, 32'(cyc - acc_cyc), 32'd4);
                seen_valid = 1'b1;
            end
            if (bus.date_done) begin
                chk({nm, "_done_cnt"}, 32'(j), 32'(N));
                chk({nm, "_ex_count"}, 32'(bus.ex_count), 32'(e_cnt));
                done = 1'b1;
            end
            ofire = bus.valid_out && bus.ready_out;
            if (acc && acc_cyc < 0) acc_cyc = cyc;
            @(posedge clk);
            if (acc) i++;
            if (ofire) j++;
            cyc++;
            if (max_acc < N && i == max_acc) return;
        end
        bus.beta_valid = 1'b0;
        if (!done) begin
            chk({nm, "_timeout"}, 32'(cyc), 32'd0);
        end else begin
            @(negedge clk);
            bus.valid_in = 1'b0;
            chk({nm, "_done_pulse"}, 32'(bus.date_done), 32'd0);
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic vec_b();
        set_vec(0, q(3),       q(10),       q(1), q(9),         1'b1, q(10));
        set_vec(1, q(3),       q(9),        q(1), q(9),         1'b1, q(9));
        set_vec(2, q(-2),      q(3),        q(8), q(4),         1'b0, q(8));
        set_vec(3, 32'h8000,   32'h4000,    q(2), 32'h4000,     1'b1, 32'h4000);
        set_vec(4, q(-3),      q(9),        q(0), q(9),         1'b1, q(9));
        set_vec(5, q(10),      q(50),       q(7), q(100),       1'b0, q(7));
        set_vec(6, q(1),       q(2),        q(0), q(1),         1'b1, q(2));
        set_vec(7, q(4),       q(16),       q(3), q(16),        1'b1, q(16));
        e_cnt = 6;
    endtask

    initial begin
        bus.beta_valid = 1'b0; bus.beta = '0; bus.valid_in = 1'b0;
        bus.s_in = '0; bus.payoff_in = '0; bus.cf_in = '0; bus.ready_out = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_beta_ready", 32'(bus.beta_ready), 32'd0);
        chk("rst_valid_out",  32'(bus.valid_out),  32'd0);
        chk("rst_ready_in",   32'(bus.ready_in),   32'd0);
        chk("rst_ex_count",   32'(bus.ex_count),   32'd0);
        rst_n = 1'b1;

        // Samples offered before any coefficients must be ignored.
        bus.valid_in = 1'b1; bus.s_in = q(1); bus.payoff_in = q(1); bus.cf_in = q(1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("idle_ready_in",  32'(bus.ready_in),  32'd0);
            chk("idle_valid_out", 32'(bus.valid_out), 32'd0);
        end
        bus.valid_in = 1'b0;

        // Flat fit C = 1.0, with a competing coefficient set offered throughout.
        set_vec(0, q(2),       32'h8000,     q(3), q(1), 1'b0, q(3));
        set_vec(1, q(5),       q(1),         q(2), q(1), 1'b1, q(1));
        set_vec(2, q(-3),      q(2),         q(4), q(1), 1'b1, q(2));
        set_vec(3, q(1),       q(0),         q(7), q(1), 1'b0, q(7));
        set_vec(4, q(0),       32'h0000FFFF, q(5), q(1), 1'b0, q(5));
        set_vec(5, q(7),       32'h00010001, q(5), q(1), 1'b1, 32'h00010001);
        set_vec(6, q(4),       q(-1),        q(6), q(1), 1'b0, q(6));
        set_vec(7, q(9),       q(3),         q(0), q(1), 1'b1, q(3));
        e_cnt = 4;
        load_beta(q(1), q(0), q(0));
        run_date("A", 1'b0, 1'b1, N, 1'b1);
        repeat (2) @(negedge clk);
        chk("ex_hold", 32'(bus.ex_count), 32'd4);

        // Pure quadratic with ready_out pattern 1,0,0.
        vec_b();
        load_beta(q(0), q(0), q(1));
        run_date("B", 1'b1, 1'b0, N, 1'b0);

        // C = S - 2: negative continuation and out-of-money paths.
        set_vec(0, q(1),  q(-1),        q(5),  q(-1), 1'b0, q(5));
        set_vec(1, q(0),  q(-1),        q(5),  q(-2), 1'b0, q(5));
        set_vec(2, q(0),  q(1),         q(5),  q(-2), 1'b1, q(1));
        set_vec(3, q(5),  q(3),         q(2),  q(3),  1'b1, q(3));
        set_vec(4, q(5),  q(2),         q(2),  q(3),  1'b0, q(2));
        set_vec(5, q(-10), 32'h1,       q(9),  q(-12), 1'b1, 32'h1);
        set_vec(6, q(2),  32'h7FFFFFFF, q(0),  q(0),  1'b1, 32'h7FFFFFFF);
        set_vec(7, q(3),  q(1),         q(-5), q(1),  1'b1, q(1));
        e_cnt = 5;
        load_beta(q(-2), q(1), q(0));
        run_date("C", 1'b0, 1'b0, N, 1'b0);

        // Saturating multiplies and adds, plus floor rounding of negative products.
        set_vec(0, 32'h01000000, q(1),         q(0), 32'h7FFFFFFF, 1'b0, q(0));
        set_vec(1, 32'hFF000000, q(5),         q(1), 32'h7FFFFFFF, 1'b0, q(1));
        set_vec(2, 32'h00000000, q(1),         q(2), q(1),         1'b1, q(1));
        set_vec(3, 32'h00000001, q(2),         q(0), q(1),         1'b1, q(2));
        set_vec(4, 32'hFFFFFFFF, 32'h8000,     q(3), q(1),         1'b0, q(3));
        set_vec(5, 32'hFFFFFFFE, 32'h00010002, q(0), 32'h00010002, 1'b1, 32'h00010002);
        set_vec(6, 32'h00000002, q(0),         q(7), 32'h00010001, 1'b0, q(7));
        set_vec(7, q(1),         32'h7FFFFFFF, q(0), 32'h7FFFFFFF, 1'b1, 32'h7FFFFFFF);
        e_cnt = 4;
        load_beta(q(1), q(0), 32'h7FFFFFFF);
        run_date("D", 1'b1, 1'b0, N, 1'b0);

        // Reset after three accepted samples, then a clean reload of the same date.
        vec_b();
        load_beta(q(0), q(0), q(1));
        run_date("R0", 1'b0, 1'b0, 3, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid_out",  32'(bus.valid_out),    32'd0);
        chk("mid_rst_cont_out",   bus.cont_out,          32'd0);
        chk("mid_rst_cf_out",     bus.cf_out,            32'd0);
        chk("mid_rst_exercise",   32'(bus.exercise_out), 32'd0);
        chk("mid_rst_date_done",  32'(bus.date_done),    32'd0);
        chk("mid_rst_ex_count",   32'(bus.ex_count),     32'd0);
        chk("mid_rst_beta_ready", 32'(bus.beta_ready),   32'd0);
        chk("mid_rst_ready_in",   32'(bus.ready_in),     32'd0);
        bus.valid_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        load_beta(q(0), q(0), q(1));
        run_date("R1", 1'b1, 1'b0, N, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/lsm_exercise_eval.md
Name: lsm_exercise_eval

Overview:
- Consumes the regression coefficients β0..β2 produced once per exercise date and evaluates the continuation value C = β0 + β1·S + β2·S² for each path at that date.
- Compares C against the immediate-exercise payoff and emits the per-path exercise decision and updated cashflow, which feeds back into the next date's accumulation.
- Sits between the regression/accumulation stage (coefficient source) and the path store/discounting stage (sink).

Parameters:
- WIDTH, fpga_cfg_pkg::FP_WIDTH, fixed-point word width.
- QINT, fpga_cfg_pkg::FP_QINT, integer bits.
- QFRAC, fpga_cfg_pkg::FP_QFRAC, fraction bits.
- N_PATHS, 10000, paths evaluated per exercise date.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- beta_valid  in  1  coefficient set available
- beta  in  3×WIDTH signed  β0, β1, β2 (Q format)
- beta_ready  out  1  block will accept a coefficient set
- valid_in  in  1  path sample valid
- ready_in  out  1  block accepts a path sample this cycle
- s_in  in  WIDTH signed  spot S_t
- payoff_in  in  WIDTH signed  immediate exercise payoff
- cf_in  in  WIDTH signed  discounted future cashflow if held
- valid_out  out  1  result valid
- ready_out  in  1  downstream accepts result
- cont_out  out  WIDTH signed  continuation value C
- exercise_out  out  1  exercise decision
- cf_out  out  WIDTH signed  updated cashflow
- date_done  out  1  one-cycle pulse once the last path of the date has been output
- ex_count  out  $clog2(N_PATHS)+1  exercises in the completed date, valid at date_done

Behaviour:
- Reset (async, rst_n=0) values:
  - all outputs 0; beta_ready=0 during reset;
  - state IDLE; pipeline valid bits cleared; counters 0.
- Reset asserted mid-date discards all in-flight samples and the loaded coefficients.
- FSM IDLE:
  - beta_ready=1, ready_in=0.
  - On beta_valid&&beta_ready, latch β0..β2 into internal registers and go to RUN.
- FSM RUN:
  - ready_in = !stall.
  - Each accepted sample increments in_cnt.
  - When in_cnt reaches N_PATHS, go to DRAIN and set ready_in=0.
- FSM DRAIN:
  - Wait until the last path leaves the pipeline (out_cnt==N_PATHS).
  - Then pulse date_done for one cycle, present ex_count, clear counters, return to IDLE.
- Pipeline is 4 stages with fixed latency of 4 cycles from accept to valid_out when unstalled:
  - S1: m1 = β2·S
  - S2: a1 = β1 + m1
  - S3: m2 = a1·S
  - S4: C = β0 + m2, decision and output register.
  - payoff_in and cf_in travel alongside in the pipeline.
- Stall:
  - stall = valid_out && !ready_out.
  - On stall the whole pipeline and the output register hold.
  - Results are never dropped or duplicated.
  - Throughput is 1 sample/cycle when ready_out=1.
- Multiply:
  - full 2·WIDTH signed product, arithmetic shift right by QFRAC (floor);
  - saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Add: WIDTH+1 bit sum, saturate to WIDTH.
- Decision:
  - exercise_out = (payoff_in > 0) && (payoff_in >= C).
  - Ties exercise; out-of-money paths never exercise.
- cf_out = exercise_out ? payoff_in : cf_in.
- ex_count increments per output with exercise_out=1. It holds its final value from date_done until the next date's first output.
- beta_valid while not in IDLE is ignored; beta_ready=0.
- valid_in while ready_in=0 is ignored.
- Coefficients are stable for a whole date.

Test Plan:
- All values Q16.16 (WIDTH=32, QFRAC=16).
- Flat fit: β=(0x00010000,0,0); S=0x00020000, payoff=0x00008000, cf_in=0x00030000 -> after 4 cycles cont_out=0x00010000, exercise_out=0, cf_out=0x00030000.
- Pure quadratic: β=(0,0,0x00010000); S=0x00030000, payoff=0x000A0000 -> cont_out=0x00090000, exercise_out=1, cf_out=0x000A0000. Repeat with payoff=0x00090000 -> exercise_out=1 (tie).
- Out-of-money / saturation:
  - payoff=0xFFFF0000 with C negative -> exercise_out=0.
  - β2=0x7FFFFFFF, S=0x01000000 -> cont_out=0x7FFFFFFF.
- Backpressure: N_PATHS=8, ready_out toggling 1,0,0,1,... -> all 8 results in order, each held while stalled, then date_done pulse with ex_count matching the reference model.
- Handshake/FSM: valid_in before beta load -> ready_in=0, nothing output. A second beta_valid during RUN -> beta_ready=0, coefficients unchanged.
- Reset mid-date: rst_n low after 3 of 8 samples -> all outputs 0, state IDLE. A fresh β load then produces 8 correct results.
